// File: rtl/lcd_bus_arbiter.sv
// Purpose: hands one LCD panel bus to one of NUM_SRC sources, draining the
//   old owner's transaction and parking the bus for GUARD_CYC cycles between owners.
// Latency: owner control/data reach the panel combinationally; an owner change
//   takes at least 2 drain cycles plus GUARD_CYC parked cycles.
// Backpressure: none; a DRAIN waits indefinitely for the owner to raise cs_n.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   sel, sel_en              requested owner index / request level (0 = release)
//   src_*                    per-source panel control and packed data
//   lcd_*                    panel control, lcd_data tri-stated while parked
//   grant                    one-hot owner while connected (OWN or DRAIN)
//   busy                     high while draining or guarding
//   switch_done              one-cycle pulse on the first cycle of a new ownership
//   sel_err                  one-cycle pulse for a request with sel >= NUM_SRC
module lcd_bus_arbiter #(
  parameter  int NUM_SRC   = 2,
  parameter  int DATA_W    = 16,
  parameter  int GUARD_CYC = 4,
  localparam int SW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SW-1:0]             sel,
  input  logic                      sel_en,
  input  logic [NUM_SRC-1:0]        src_cs_n,
  input  logic [NUM_SRC-1:0]        src_wr_n,
  input  logic [NUM_SRC-1:0]        src_rd_n,
  input  logic [NUM_SRC-1:0]        src_rs,
  input  logic [NUM_SRC-1:0]        src_reset_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      lcd_cs_n,
  output logic                      lcd_wr_n,
  output logic                      lcd_rd_n,
  output logic                      lcd_rs,
  output logic                      lcd_reset_n,
  output wire  [DATA_W-1:0]         lcd_data,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      busy,
  output logic                      switch_done,
  output logic                      sel_err
);

  typedef enum logic [1:0] {PARK, OWN, DRAIN, GUARD} state_e;

  localparam logic [SW:0] SRC_LIM = (SW+1)'(NUM_SRC);
  localparam logic [7:0]  GUARD_L = 8'(GUARD_CYC);

  state_e        state_q, state_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [SW-1:0] target_q, target_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          cs_hi_q, cs_hi_d;   // previous DRAIN cycle saw owner cs_n high
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic sel_in_range, sel_valid, owner_cs_n, connected;

  assign sel_in_range = ({1'b0, sel} < SRC_LIM);
  assign sel_valid    = sel_en && sel_in_range;
  assign owner_cs_n   = src_cs_n[owner_q];
  assign connected    = (state_q == OWN) || (state_q == DRAIN);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    // Last valid request wins in every state; invalid requests leave it alone.
    target_d = sel_valid ? sel : target_q;
    cnt_d    = cnt_q;
    cs_hi_d  = cs_hi_q;
    done_d   = 1'b0;
    err_d    = sel_en && !sel_in_range;

    unique case (state_q)
      PARK: begin
        if (sel_valid) begin
          state_d = GUARD;
          cnt_d   = GUARD_L;
        end
      end
      OWN: begin
        if (!sel_en || (sel_valid && (sel != owner_q))) begin
          state_d = DRAIN;
          cs_hi_d = 1'b0;
        end
      end
      DRAIN: begin
        if (sel_valid && (sel == owner_q)) begin
          state_d = OWN;  // cancelled switch: no pulse, no idle gap
        end else if (owner_cs_n) begin
          if (cs_hi_q) begin
            state_d = GUARD;
            cnt_d   = GUARD_L;
            cs_hi_d = 1'b0;
          end else begin
            cs_hi_d = 1'b1;
          end
        end else begin
          cs_hi_d = 1'b0;
        end
      end
      GUARD: begin
        // The counter reaches 0 on the cycle it holds 1, so exactly
        // GUARD_CYC cycles are spent parked before the decision.
        if (cnt_q > 8'd1) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (sel_valid) begin
            state_d = OWN;
            owner_d = target_d;
            done_d  = 1'b1;
          end else if (!sel_en) begin
            state_d = PARK;
          end
          // An invalid request at expiry is ignored: hold parked at zero.
        end
      end
      default: state_d = PARK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PARK;
      owner_q  <= '0;
      target_q <= '0;
      cnt_q    <= 8'd0;
      cs_hi_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      cs_hi_q  <= cs_hi_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    lcd_cs_n    = 1'b1;
    lcd_wr_n    = 1'b1;
    lcd_rd_n    = 1'b1;
    lcd_rs      = 1'b0;
    lcd_reset_n = 1'b1;
    grant       = '0;
    if (connected) begin
      lcd_cs_n    = src_cs_n[owner_q];
      lcd_wr_n    = src_wr_n[owner_q];
      lcd_rd_n    = src_rd_n[owner_q];
      lcd_rs      = src_rs[owner_q];
      lcd_reset_n = src_reset_n[owner_q];
      grant       = NUM_SRC'(1) << owner_q;
    end
  end

  assign lcd_data    = connected ? src_data[int'(owner_q)*DATA_W +: DATA_W] : {DATA_W{1'bz}};
  assign busy        = (state_q == DRAIN) || (state_q == GUARD);
  assign switch_done = done_q;
  assign sel_err     = err_q;

endmodule
